// File: rtl/load_store_unit.sv
// Load/store unit between the RV32 core result stage and a handshaked data bus.
// Formats byte/half/word stores and loads, stalls the core while an access is outstanding.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_stall,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_misaligned,
  output logic        o_bus_error,
  output logic        o_mem_valid,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_wdata;
  logic             r_mem_valid;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_misaligned;
  logic             r_bus_error;

  logic             w_misaligned;
  logic             w_illegal;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_data;

  // Request decode: alignment, legality and store lane formatting
  always_comb begin
    w_misaligned = 1'b0;
    w_illegal    = 1'b0;
    w_wstrb      = 4'b0000;
    w_wdata      = i_req_wdata;
    case (i_req_funct3)
      3'b000: begin
        w_wstrb = 4'b0001 << i_req_addr[1:0];
        w_wdata = {4{i_req_wdata[7:0]}};
      end
      3'b001: begin
        w_misaligned = i_req_addr[0];
        w_wstrb      = 4'b0011 << {i_req_addr[1], 1'b0};
        w_wdata      = {2{i_req_wdata[15:0]}};
      end
      3'b010: begin
        w_misaligned = |i_req_addr[1:0];
        w_wstrb      = 4'b1111;
      end
      3'b100: w_illegal = i_req_we;
      3'b101: begin
        w_misaligned = !i_req_we && i_req_addr[0];
        w_illegal    = i_req_we;
      end
      default: w_illegal = 1'b1;
    endcase
    if (!i_req_we) w_wstrb = 4'b0000;
  end

  // Load lane extraction and sign/zero extension from the captured access
  always_comb begin
    w_byte      = 8'(i_mem_rdata >> {r_addr_lo, 3'b000});
    w_half      = r_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    w_load_data = i_mem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = i_mem_rdata;
    endcase
  end

  // The core must see the stall in the same cycle it presents the request
  assign o_stall = ((r_state == S_IDLE) && i_req_valid) || (r_state == S_REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wstrb      <= 4'd0;
      r_wdata      <= 32'd0;
      r_mem_valid  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= 32'd0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_rsp_valid  <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            if (w_misaligned) begin
              r_state      <= S_ERR;
              r_rsp_valid  <= 1'b1;
              r_misaligned <= 1'b1;
              r_rsp_rdata  <= 32'd0;
            end else if (w_illegal) begin
              r_state     <= S_ERR;
              r_rsp_valid <= 1'b1;
              r_bus_error <= 1'b1;
              r_rsp_rdata <= 32'd0;
            end else begin
              r_state     <= S_REQ;
              r_cnt       <= '0;
              r_mem_valid <= 1'b1;
              r_we        <= i_req_we;
              r_funct3    <= i_req_funct3;
              r_addr_lo   <= i_req_addr[1:0];
              r_addr      <= {i_req_addr[31:2], 2'b00};
              r_wstrb     <= w_wstrb;
              r_wdata     <= w_wdata;
            end
          end
        end
        S_REQ: begin
          // A ready on the last allowed cycle still completes normally
          if (i_mem_ready) begin
            r_state     <= S_RESP;
            r_mem_valid <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_we ? 32'd0 : w_load_data;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= S_ERR;
            r_mem_valid <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_bus_error <= 1'b1;
            r_rsp_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_misaligned = r_misaligned;
  assign o_bus_error  = r_bus_error;
  assign o_mem_valid  = r_mem_valid;
  assign o_mem_we     = r_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_wstrb  = r_wstrb;
  assign o_mem_wdata  = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-lane reference model.
module tb_load_store_unit;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_stall;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_misaligned;
  logic        o_bus_error;
  logic        o_mem_valid;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_stall      (o_stall),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_misaligned (o_misaligned),
    .o_bus_error  (o_bus_error),
    .o_mem_valid  (o_mem_valid),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wstrb  (o_mem_wstrb),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete core access; ready_at is the REQ cycle index that sees mem_ready, -1 for never
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int ready_at);
    int          size;
    int          lo;
    bit          legal;
    bit          mis;
    bit          to;
    int          n_req;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] exp_rdata;

    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    lo    = int'(addr[1:0]);
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis   = legal && ((lo % size) != 0);
    to    = !(ready_at >= 0 && ready_at < int'(TIMEOUT));
    n_req = to ? int'(TIMEOUT) : ready_at + 1;
    exp_wstrb = we ? 4'(((1 << size) - 1) << lo) : 4'd0;
    for (int k = 0; k < 4; k++) exp_wdata[8*k +: 8] = wdata[8*(k % size) +: 8];
    shifted   = rdata >> (8 * lo);
    mask      = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    exp_rdata = shifted & mask;
    if (!f3[2] && size < 4 && exp_rdata[8*size-1]) exp_rdata = exp_rdata | ~mask;
    if (we) exp_rdata = 32'd0;

    @(posedge clk); #1;
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
    i_mem_ready  = 1'($urandom_range(0, 1));
    i_mem_rdata  = $urandom;
    @(negedge clk);
    check("idle_stall", 32'(o_stall), 32'd1);
    check("idle_mem_valid", 32'(o_mem_valid), 32'd0);
    check("idle_rsp_valid", 32'(o_rsp_valid), 32'd0);

    if (legal && !mis) begin
      for (int i = 0; i < n_req; i++) begin
        @(posedge clk); #1;
        i_mem_ready = (i == ready_at);
        i_mem_rdata = (i == ready_at) ? rdata : $urandom;
        @(negedge clk);
        check("req_mem_valid", 32'(o_mem_valid), 32'd1);
        check("req_stall", 32'(o_stall), 32'd1);
        check("req_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("req_mem_addr", o_mem_addr, {addr[31:2], 2'b00});
        check("req_mem_we", 32'(o_mem_we), 32'(we));
        check("req_mem_wstrb", 32'(o_mem_wstrb), 32'(exp_wstrb));
        if (we) check("req_mem_wdata", o_mem_wdata, exp_wdata);
      end
    end

    @(posedge clk); #1;
    i_mem_ready = 1'($urandom_range(0, 1));
    i_mem_rdata = $urandom;
    @(negedge clk);
    check("done_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("done_stall", 32'(o_stall), 32'd0);
    check("done_mem_valid", 32'(o_mem_valid), 32'd0);
    check("done_misaligned", 32'(o_misaligned), 32'(mis));
    check("done_bus_error", 32'(o_bus_error), 32'(!mis && (!legal || to)));
    if (legal && !mis && !to) check("done_rdata", o_rsp_rdata, exp_rdata);

    @(posedge clk); #1;
    i_req_valid = 1'b0;
    i_mem_ready = 1'b0;
    @(negedge clk);
    check("after_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("after_mem_valid", 32'(o_mem_valid), 32'd0);
    check("after_stall", 32'(o_stall), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_funct3 = 3'd0;
    i_req_addr   = 32'd0;
    i_req_wdata  = 32'd0;
    i_mem_ready  = 1'b0;
    i_mem_rdata  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    check("rst_mem_valid", 32'(o_mem_valid), 32'd0);
    check("rst_mem_wstrb", 32'(o_mem_wstrb), 32'd0);
    check("rst_flags", {30'd0, o_misaligned, o_bus_error}, 32'd0);
    reset = 1'b0;

    // Directed cases
    access(1'b0, 3'b010, 32'h64, 32'h0, 32'h0000_0019, 0);
    access(1'b1, 3'b000, 32'h61, 32'hAABB_CCDD, 32'h0, 0);
    access(1'b1, 3'b001, 32'h62, 32'hAABB_CCDD, 32'h0, 1);
    access(1'b0, 3'b000, 32'h63, 32'h0, 32'h80FF_7F01, 0);
    access(1'b0, 3'b100, 32'h63, 32'h0, 32'h80FF_7F01, 2);
    access(1'b0, 3'b001, 32'h62, 32'h0, 32'h80FF_7F01, 0);
    access(1'b0, 3'b101, 32'h62, 32'h0, 32'h80FF_7F01, 0);
    access(1'b0, 3'b010, 32'h66, 32'h0, 32'h0, 0);
    access(1'b0, 3'b011, 32'h64, 32'h0, 32'h0, 0);
    access(1'b1, 3'b011, 32'h65, 32'h0, 32'h0, 0);
    access(1'b0, 3'b010, 32'h70, 32'h0, 32'h1234_5678, -1);
    access(1'b0, 3'b010, 32'h70, 32'h0, 32'h1234_5678, int'(TIMEOUT) - 1);
    access(1'b1, 3'b010, 32'h7C, 32'hCAFE_F00D, 32'h0, int'(TIMEOUT));

    // Reset while a request is outstanding
    @(posedge clk); #1;
    i_req_valid  = 1'b1;
    i_req_we     = 1'b0;
    i_req_funct3 = 3'b010;
    i_req_addr   = 32'h100;
    i_mem_ready  = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_mem_valid", 32'(o_mem_valid), 32'd1);
    #1;
    reset       = 1'b1;
    i_req_valid = 1'b0;
    #1;
    check("mid_rst_mem_valid", 32'(o_mem_valid), 32'd0);
    check("mid_rst_stall", 32'(o_stall), 32'd0);
    check("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("post_rst_mem_valid", 32'(o_mem_valid), 32'd0);
    access(1'b0, 3'b010, 32'h104, 32'h0, 32'hDEAD_BEEF, 0);

    // Randomized accesses
    for (int n = 0; n < 300; n++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, TIMEOUT + 1) - 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
